// File: rtl/race_pkg.sv
// Shared types and constants for the race game blocks: state encoding,
// LFSR polynomial, obstacle pattern decode and lane/row screen positions.
package race_pkg;

    localparam int          INDEX_W      = 3;
    localparam int          NUM_PATTERNS = 6;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    // Impossible index, so the first draw after a (re)start is never nudged.
    localparam logic [INDEX_W-1:0] NO_INDEX = 3'd7;

    localparam logic [9:0] LANE_X0 = 10'h0C5;
    localparam logic [9:0] LANE_X1 = 10'h117;
    localparam logic [9:0] LANE_X2 = 10'h169;
    localparam logic [9:0] ROW_Y   = 10'h262;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        OFFER,
        WAIT
    } seq_state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Fold 0..7 onto 0..5, then bump to the next pattern if it would repeat.
    function automatic logic [INDEX_W-1:0] pick_index(input logic [15:0]        value,
                                                      input logic [INDEX_W-1:0] prev);
        logic [INDEX_W-1:0] raw;
        logic [INDEX_W-1:0] cand;
        raw  = value[INDEX_W-1:0];
        cand = (raw >= INDEX_W'(NUM_PATTERNS)) ? raw - INDEX_W'(NUM_PATTERNS) : raw;
        if (cand == prev) begin
            cand = (cand == INDEX_W'(NUM_PATTERNS - 1)) ? '0 : cand + 1'b1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit Galois LFSR with seed reload and advance enable; shared by game blocks.
module game_lfsr16
    import race_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    // An all-zero state would lock up the register forever.
    localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SAFE_SEED;
        end else if (load) begin
            value <= SAFE_SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/obstacle_index_sequencer.sv
// Issues one pseudo-random obstacle pattern index per wave over a valid/ack
// handshake, pacing waves by a frame-tick counter.
module obstacle_index_sequencer
    import race_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          FRAMES_PER_WAVE = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               frame_tick,
    input  logic               index_ack,
    output logic [INDEX_W-1:0] index,
    output logic               index_valid,
    output logic [7:0]         wave_count,
    output logic               busy
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_WAVE - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [15:0]        lfsr_value;
    logic [INDEX_W-1:0] prev_index;
    logic [INDEX_W-1:0] drawn;
    logic [7:0]         frame_cnt;
    logic               lfsr_load;
    logic               lfsr_advance;
    logic               handshake;
    logic               count_frame;
    logic               last_frame;

    game_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (lfsr_load),
        .advance(lfsr_advance),
        .value  (lfsr_value)
    );

    assign drawn      = pick_index(lfsr_step(lfsr_value), prev_index);
    assign last_frame = (frame_cnt == LAST_FRAME);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop overrides every other input in every state.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = ISSUE;
                ISSUE:   state_next = OFFER;
                OFFER:   if (index_ack) state_next = WAIT;
                WAIT:    if (frame_tick && !pause && last_frame) state_next = ISSUE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        index_valid  = (state == OFFER);
        lfsr_load    = (state == IDLE)  && start && !stop;
        lfsr_advance = (state == ISSUE) && !stop;
        handshake    = (state == OFFER) && index_ack && !stop;
        count_frame  = (state == WAIT)  && frame_tick && !pause && !stop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index      <= '0;
            prev_index <= NO_INDEX;
            wave_count <= '0;
            frame_cnt  <= '0;
        end else begin
            if (lfsr_load) begin
                prev_index <= NO_INDEX;
                wave_count <= '0;
            end
            if (lfsr_advance) begin
                index      <= drawn;
                prev_index <= drawn;
            end
            if (handshake) begin
                frame_cnt <= '0;
                if (wave_count != 8'hFF) begin
                    wave_count <= wave_count + 8'd1;
                end
            end
            if (count_frame) begin
                frame_cnt <= last_frame ? 8'd0 : frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_obstacle_index_sequencer.sv
// Directed bench for obstacle_index_sequencer with a scoreboard of expected
// indices produced by a reference LFSR model.
module tb_obstacle_index_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       frame_tick;
    logic       index_ack;
    logic [2:0] index;
    logic       index_valid;
    logic [7:0] wave_count;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  m_prev;
    int          exp_wc;
    logic [2:0]  exp_q[$];
    logic [2:0]  cur_exp;
    logic [2:0]  last_idx;

    always #5 clk = ~clk;

    obstacle_index_sequencer #(
        .LFSR_SEED      (16'hACE1),
        .FRAMES_PER_WAVE(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .frame_tick (frame_tick),
        .index_ack  (index_ack),
        .index      (index),
        .index_valid(index_valid),
        .wave_count (wave_count),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic model_start();
        m_lfsr = 16'hACE1;
        m_prev = 3'd7;
        exp_wc = 0;
        exp_q.delete();
    endtask

    // Reference draw: Galois step, fold onto 0..5, no immediate repeat.
    task automatic model_draw();
        logic [2:0] raw;
        logic [2:0] cand;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        raw    = m_lfsr[2:0];
        cand   = (raw > 3'd5) ? raw - 3'd6 : raw;
        if (cand == m_prev) cand = (cand == 3'd5) ? 3'd0 : cand + 3'd1;
        m_prev = cand;
        exp_q.push_back(cand);
    endtask

    task automatic take_wave(input string tag);
        check({tag, "_valid"}, index_valid, 1);
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            check({tag, "_index"}, index, cur_exp);
        end
    endtask

    task automatic ack_wave(input string tag);
        index_ack = 1'b1;
        step(1);
        index_ack = 1'b0;
        if (exp_wc < 255) exp_wc++;
        check({tag, "_valid_drop"}, index_valid, 0);
        check({tag, "_wave_count"}, wave_count, exp_wc);
        check({tag, "_busy"}, busy, 1);
        model_draw();
    endtask

    task automatic gap(input int period, input string tag);
        bit found;
        found = 0;
        for (int cyc = 0; cyc < 600 && !found; cyc++) begin
            frame_tick = (cyc % period == 0);
            step(1);
            frame_tick = 1'b0;
            if (index_valid === 1'b1) found = 1;
        end
        check({tag, "_timeout"}, found, 1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        frame_tick = 1'b0;
        index_ack  = 1'b0;
        #12;
        check("rst_index", index, 0);
        check("rst_valid", index_valid, 0);
        check("rst_wave_count", wave_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step(1);

        // First run: latency, known first three indices, long ack hold.
        model_start();
        model_draw();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("lat_issue_valid", index_valid, 0);
        check("lat_issue_busy", busy, 1);
        step(1);
        take_wave("w1");
        check("w1_const", index, 0);
        ack_wave("w1");
        gap(4, "w1_gap");
        take_wave("w2");
        check("w2_const", index, 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("hold_valid", index_valid, 1);
            check("hold_index", index, cur_exp);
        end
        ack_wave("w2");
        gap(4, "w2_gap");
        take_wave("w3");
        check("w3_const", index, 4);
        ack_wave("w3");

        // Exact tick count to next issue.
        pulse_tick();
        step(1);
        check("t1_valid", index_valid, 0);
        pulse_tick();
        step(1);
        check("t2_valid", index_valid, 0);
        pulse_tick();
        check("t3_issue", index_valid, 0);
        step(1);
        take_wave("w4");

        // Ticks during OFFER must not advance the wave gap.
        frame_tick = 1'b1;
        step(3);
        frame_tick = 1'b0;
        check("offer_tick_valid", index_valid, 1);
        ack_wave("w4");

        // ack outside OFFER ignored; paused tick not counted.
        index_ack = 1'b1;
        step(1);
        index_ack = 1'b0;
        check("stray_ack_wc", wave_count, exp_wc);
        pulse_tick();
        pause = 1'b1;
        pulse_tick();
        pause = 1'b0;
        pulse_tick();
        step(2);
        check("pause_valid", index_valid, 0);
        pulse_tick();
        check("pause_t4_issue", index_valid, 0);
        step(1);
        take_wave("w5");

        // stop during OFFER.
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_valid", index_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_index", index, cur_exp);
        check("stop_wc", wave_count, exp_wc);
        pulse_tick();
        step(1);
        check("idle_tick_busy", busy, 0);

        // Restart reseeds.
        model_start();
        model_draw();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_valid0", index_valid, 0);
        step(1);
        take_wave("r1");
        check("r1_const", index, 0);
        check("r1_wc", wave_count, 0);

        // Long run: saturation, legal range, no repeats.
        last_idx = cur_exp;
        for (int w = 0; w < 300; w++) begin
            ack_wave("long");
            gap(1, "long_gap");
            take_wave("long");
            check("long_range", index < 3'd6, 1);
            check("long_norepeat", index != last_idx, 1);
            last_idx = cur_exp;
        end
        check("sat_wc", wave_count, 255);

        // Asynchronous reset mid-OFFER.
        check("pre_rst_valid", index_valid, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_valid", index_valid, 0);
        check("async_rst_index", index, 0);
        check("async_rst_wc", wave_count, 0);
        check("async_rst_busy", busy, 0);
        #2 reset = 1'b0;
        step(2);
        check("post_rst_valid", index_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_index_sequencer.md
Name: obstacle_index_sequencer

Overview:
- Generates the 3-bit obstacle-pattern index (0..5) consumed by the obstacle position ROM, one index per wave.
- Pseudo-random choice from a 16-bit Galois LFSR with a no-immediate-repeat rule.
- Paced by the per-frame tick; issues each index over a valid/ack handshake to the scroll/render logic.
- Sits between the game-control FSM (start/stop/pause) and the position ROM.

Parameters:
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset and on every start. A value of 0 is replaced by 16'h0001.
- FRAMES_PER_WAVE, 60: number of counted frame_tick pulses between handshake completion and the next issue. Legal range 1..255.
- NUM_PATTERNS, 6: number of legal indices. Fixed at 6; the ROM decodes 0..5.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse; begins a run from IDLE.
- stop, input, 1: level or pulse; returns the block to IDLE from any state.
- pause, input, 1: level; freezes the wave-gap frame counter.
- frame_tick, input, 1: one-cycle pulse per video frame.
- index_ack, input, 1: downstream has latched index.
- index, output, 3: current pattern index, registered.
- index_valid, output, 1: index is offered to downstream.
- wave_count, output, 8: completed handshakes since start; saturates at 255.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: index=0, index_valid=0, wave_count=0, busy=0, state=IDLE, lfsr=LFSR_SEED, frame counter=0, prev_index=7 (an impossible index, so the first draw is never altered).
- States:
  - IDLE: start=1 and stop=0 -> ISSUE. On that start cycle, lfsr reloads LFSR_SEED, prev_index reloads 7, wave_count clears.
  - ISSUE: lasts one cycle, then -> OFFER.
    - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0); lfsr is updated to lfsr_next.
    - raw = lfsr_next[2:0]; cand = (raw>=6) ? raw-6 : raw.
    - If cand==prev_index: cand = (cand==5) ? 0 : cand+1.
    - index and prev_index are registered to cand.
  - OFFER: index_valid=1, index held stable. On index_ack=1: index_valid drops next cycle, wave_count increments (saturating at 255), frame counter clears, -> WAIT.
  - WAIT: on each frame_tick with pause=0, the counter increments. When frame_tick arrives with counter==FRAMES_PER_WAVE-1 and pause=0: -> ISSUE and counter clears. ticks with pause=1 are ignored; the count is retained.
- Latency: start sampled in cycle n -> ISSUE in n+1 -> index_valid=1 in n+2.
- index_ack in the same cycle that index_valid rises completes the handshake; minimum OFFER length is one cycle. index_ack outside OFFER is ignored.
- stop in any state: next state IDLE, index_valid=0 the next cycle, index retains its last value, lfsr and wave_count retain their values. stop has priority over start, ack and tick in the same cycle.
- frame_tick while in IDLE, ISSUE or OFFER is ignored.
- pause has no effect on the OFFER handshake.
- Asserting reset mid-handshake drops index_valid immediately (asynchronous) and restores all reset values.
- index is never 6 or 7 after the first ISSUE.

Decomposition:
- Shared package race_pkg holds:
  - INDEX_W=3, NUM_PATTERNS=6
  - LFSR_TAPS=16'hB400
  - the state enum {IDLE, ISSUE, OFFER, WAIT}
  - LANE_X0=10'h0C5, LANE_X1=10'h117, LANE_X2=10'h169, ROW_Y=10'h262
- One sub-module, game_lfsr16: seed load, advance enable, 16-bit state output. It is reusable by the other game blocks.

Test Plan:
- Default seed, start pulse, immediate ack each wave, frame_tick every 4 cycles:
  - wave 1 -> index 0, lfsr 16'hE270.
  - wave 2 -> raw 0 repeats prev, so index 1, lfsr 16'h7138.
  - wave 3 -> index 4, lfsr 16'h389C.
  - wave_count 1, 2, 3.
- Start in cycle n -> index_valid=1 in cycle n+2. Hold ack low 10 cycles -> index and index_valid stable for all 10 cycles.
- FRAMES_PER_WAVE=3, ack, then 3 ticks -> next index_valid 2 cycles after the 3rd tick. pause=1 during the 2nd tick -> 4 ticks are required.
- stop asserted during OFFER -> index_valid=0 the next cycle, busy=0, index unchanged. Then start -> first index 0 again (reseeded).
- Run 300 waves -> wave_count saturates at 255, and index stays in 0..5 with no two consecutive equal values.
- reset asserted mid-OFFER, asynchronously between clock edges -> index_valid=0, index=0 and wave_count=0 before the next clk edge.
